// File: rtl/arr_stim.sv
// arr_stim: LFSR stimulus source and self-checker in front of the arr comparators.
// Drives data_op into an external delay path and presents the LATENCY-delayed copy on exp_op.
// Counts obs_ip/exp_op mismatches and finishes the run as DONE (N_VECTORS compared) or FAIL (ERR_LIMIT reached).
module arr_stim #(
   parameter int          WIDTH     = 32,
   parameter int          LATENCY   = 2,
   parameter int          N_VECTORS = 16,
   parameter int          ERR_LIMIT = 4,
   parameter logic [31:0] SEED      = 32'h00000001
) (
   input  logic             arr_stim_clk_ip,
   input  logic             arr_stim_rst_n_ip,
   input  logic             en_ip,
   input  logic             inject_ip,
   input  logic [WIDTH-1:0] obs_ip,
   output logic [WIDTH-1:0] data_op,
   output logic [WIDTH-1:0] exp_op,
   output logic             valid_op,
   output logic [7:0]       mismatch_cnt_op,
   output logic             done_op,
   output logic             fail_op
);

   typedef enum logic [2:0] {IDLE, FILL, RUN, DONE, FAIL} state_t;

   localparam logic [31:0] TAPS      = 32'h80200003;
   localparam logic [7:0]  ERR_LIM8  = 8'(ERR_LIMIT);
   localparam logic [15:0] NVEC16    = 16'(N_VECTORS);
   localparam logic [3:0]  FILL_LAST = 4'(LATENCY - 1);

   state_t           state_q;
   logic [31:0]      lfsr_q;
   logic [31:0]      lfsr_d;
   logic [WIDTH-1:0] pipe_q [LATENCY];
   logic [WIDTH-1:0] data_d;
   logic             inj_q;
   logic [7:0]       mis_q;
   logic [7:0]       mis_d;
   logic [15:0]      vec_q;
   logic [15:0]      vec_d;
   logic [3:0]       fill_q;
   logic             done_q;
   logic             fail_q;
   logic             mismatch;
   logic             advance;

   // Next LFSR value, replicated stimulus, aligned expected value and post-update counters
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      data_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         data_d[i] = lfsr_q[i[4:0]];
      end
      // The LFSR value is shown while running and held (frozen) in DONE/FAIL; IDLE drives zero
      data_op  = (state_q == IDLE) ? '0 : data_d;
      exp_op   = pipe_q[LATENCY-1] ^ WIDTH'(inj_q);
      mismatch = (obs_ip != exp_op);
      mis_d    = (mismatch && (mis_q != 8'hFF)) ? mis_q + 8'd1 : mis_q;
      vec_d    = vec_q + 16'd1;
      advance  = en_ip && ((state_q == FILL) || (state_q == RUN));
   end

   assign valid_op        = (state_q == RUN);
   assign mismatch_cnt_op = mis_q;
   assign done_op         = done_q;
   assign fail_op         = fail_q;

   // LFSR and expected-value pipeline: shift while running, reload/clear whenever en_ip is low
   always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
      if (!arr_stim_rst_n_ip) begin
         lfsr_q <= SEED;
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (!en_ip) begin
         lfsr_q <= SEED;
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (advance) begin
         lfsr_q    <= lfsr_d;
         pipe_q[0] <= data_op;
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Run control: fill the pipeline, compare N_VECTORS vectors, latch DONE or FAIL
   always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
      if (!arr_stim_rst_n_ip) begin
         state_q <= IDLE;
         inj_q   <= 1'b0;
         mis_q   <= 8'd0;
         vec_q   <= 16'd0;
         fill_q  <= 4'd0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               inj_q <= 1'b0;
               if (en_ip) begin
                  state_q <= FILL;
                  mis_q   <= 8'd0;
                  vec_q   <= 16'd0;
                  fill_q  <= 4'd0;
                  done_q  <= 1'b0;
                  fail_q  <= 1'b0;
               end
            end
            FILL: begin
               if (!en_ip) begin
                  state_q <= IDLE;
               end else if (fill_q == FILL_LAST) begin
                  state_q <= RUN;
               end else begin
                  fill_q <= fill_q + 4'd1;
               end
            end
            RUN: begin
               if (!en_ip) begin
                  state_q <= IDLE;
                  inj_q   <= 1'b0;
               end else begin
                  mis_q <= mis_d;
                  vec_q <= vec_d;
                  // A pending corruption blocks new requests until it has been applied
                  inj_q <= inject_ip && !inj_q;
                  if (mis_d >= ERR_LIM8) begin
                     state_q <= FAIL;
                     fail_q  <= 1'b1;
                     inj_q   <= 1'b0;
                  end else if (vec_d >= NVEC16) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     inj_q   <= 1'b0;
                  end
               end
            end
            DONE, FAIL: begin
               if (!en_ip) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
